vcore_axim_mem_responder: RTL and testbench
===========================================

Name: vcore_axim_mem_responder

Overview:
Slave-side counterpart of the vector core's AXIM control/stream interface. It accepts read and write transfer requests on the ctrl_* ports. Reads are served from a local word-addressed memory as an rd_t* stream; write streams on wr_t* are absorbed into the same memory. Used as the memory end for vector-core bring-up and unit benches, so the core's memory control unit can run without a full AXI interconnect.

Parameters:
C_M_AXI_ADDR_WIDTH, 32, byte address width of the transfer offsets
C_M_AXI_DATA_WIDTH, 32, stream beat width; byte lanes BL = C_M_AXI_DATA_WIDTH/8
C_XFER_SIZE_WIDTH, 32, width of the transfer size in bytes
MEM_DEPTH, 1024, memory depth in beats (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ctrl_raddr_offset_i  in  C_M_AXI_ADDR_WIDTH  read start byte address, sampled on ctrl_rstart_i
ctrl_rxfer_size_i  in  C_XFER_SIZE_WIDTH  read size in bytes, sampled on ctrl_rstart_i
ctrl_rstart_i  in  1  one-cycle read request pulse
ctrl_rdone_o  out  1  one-cycle read completion pulse
rd_tdata_o  out  C_M_AXI_DATA_WIDTH  read beat data
rd_tvalid_o  out  1  read beat valid
rd_tready_i  in  1  consumer ready
rd_tlast_o  out  1  final beat of the read transfer
ctrl_waddr_offset_i  in  C_M_AXI_ADDR_WIDTH  write start byte address
ctrl_wxfer_size_i  in  C_XFER_SIZE_WIDTH  write size in bytes
ctrl_wstart_i  in  1  one-cycle write request pulse
ctrl_wdone_o  out  1  one-cycle write completion pulse
wr_tdata_i  in  C_M_AXI_DATA_WIDTH  write beat data
wr_tvalid_i  in  1  write beat valid
wr_tready_o  out  1  responder ready for a write beat
ctrl_wstrb_msk_en_i  in  1  1: apply wr_tstrb_msk_i; 0: all byte lanes written
wr_tstrb_msk_i  in  BL  per-beat byte enable

Behaviour:
- Reset: all outputs 0; both FSMs return to IDLE and counters clear. Memory contents are preserved. A reset in the middle of a transfer aborts it, and no done pulse is issued.
- Addressing: word index = offset[log2(BL) +: log2(MEM_DEPTH)]. The index increments by 1 per beat and wraps modulo MEM_DEPTH. Low offset bits are ignored.
- Beat count N = ceil(size/BL), computed at start in C_XFER_SIZE_WIDTH+1 bits.
- Read FSM R_IDLE -> R_STREAM -> R_DONE -> R_IDLE:
  - R_IDLE: on ctrl_rstart_i, latch address and N. If N = 0, go to R_DONE with no beats issued.
  - Memory is synchronous with 1-cycle read latency. The first rd_tvalid_o is asserted 2 cycles after the start pulse.
  - AXI-stream rules apply: once rd_tvalid_o is asserted, rd_tdata_o and rd_tlast_o stay stable until rd_tready_i is high. rd_tvalid_o never drops mid-transfer once data is available.
  - With rd_tready_i held high, the stream sustains 1 beat per cycle. A prefetch/skid register is required.
  - rd_tlast_o is high only on beat N.
  - After the tlast handshake, enter R_DONE. ctrl_rdone_o pulses for exactly 1 cycle, then the FSM returns to R_IDLE.
- Write FSM W_IDLE -> W_ACCEPT -> W_DONE -> W_IDLE:
  - W_IDLE: on ctrl_wstart_i, latch address and N. If N = 0, go directly to W_DONE.
  - W_ACCEPT: wr_tready_o = 1. Each cycle with wr_tvalid_i && wr_tready_o writes one beat.
  - Byte enables = wr_tstrb_msk_i if ctrl_wstrb_msk_en_i, else all ones. ctrl_wstrb_msk_en_i is sampled per beat.
  - After beat N is accepted, wr_tready_o drops in the next cycle and ctrl_wdone_o pulses for 1 cycle (W_DONE).
- A start pulse received while the respective FSM is not in IDLE is ignored.
- The read and write channels are fully independent and may run concurrently.
- Read and write to the same word in the same cycle: the read returns the old data (read-first).

Test Plan:
- Write 16 B at 0x40: beats 0x11111111..0x44444444, strb mask disabled -> 4 beats accepted, ctrl_wdone_o pulses once, 1 cycle after the 4th handshake.
- Read 16 B at 0x40, rd_tready_i = 1 -> first tvalid 2 cycles after start; 4 back-to-back beats 0x11111111..0x44444444; tlast on beat 4; rdone 1 cycle after the last beat.
- Read with rd_tready_i toggling 1,0,0,1,... -> data and tlast held stable during stalls; no beat lost or duplicated.
- Masked write 4 B at 0x40, data 0xAABBCCDD, strb 4'b0101, mask enabled -> read back 0x11BB11DD.
- Read 8 B at (MEM_DEPTH-1)*4 -> beats from word MEM_DEPTH-1, then word 0 (wrap).
- ctrl_rstart_i with size 0 -> no tvalid, rdone pulse. Second rstart mid-stream -> ignored. Reset mid-stream -> tvalid = 0 next cycle, no rdone, memory retained.

Source files
------------

// File: rtl/vcore_axim_mem_responder_if.sv
// Control and stream bundle between the vector core's memory control unit (master)
// and the memory responder (slave).
interface vcore_axim_mem_responder_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32
);
    localparam int unsigned BL = C_M_AXI_DATA_WIDTH / 8;

    // Read request / completion and read stream
    logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i;
    logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i;
    logic                          ctrl_rstart_i;
    logic                          ctrl_rdone_o;
    logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o;
    logic                          rd_tvalid_o;
    logic                          rd_tready_i;
    logic                          rd_tlast_o;

    // Write request / completion and write stream
    logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_waddr_offset_i;
    logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_wxfer_size_i;
    logic                          ctrl_wstart_i;
    logic                          ctrl_wdone_o;
    logic [C_M_AXI_DATA_WIDTH-1:0] wr_tdata_i;
    logic                          wr_tvalid_i;
    logic                          wr_tready_o;
    logic                          ctrl_wstrb_msk_en_i;
    logic [BL-1:0]                 wr_tstrb_msk_i;

    modport master (
        output ctrl_raddr_offset_i, ctrl_rxfer_size_i, ctrl_rstart_i, rd_tready_i,
        output ctrl_waddr_offset_i, ctrl_wxfer_size_i, ctrl_wstart_i,
        output wr_tdata_i, wr_tvalid_i, ctrl_wstrb_msk_en_i, wr_tstrb_msk_i,
        input  ctrl_rdone_o, rd_tdata_o, rd_tvalid_o, rd_tlast_o,
        input  ctrl_wdone_o, wr_tready_o
    );

    modport slave (
        input  ctrl_raddr_offset_i, ctrl_rxfer_size_i, ctrl_rstart_i, rd_tready_i,
        input  ctrl_waddr_offset_i, ctrl_wxfer_size_i, ctrl_wstart_i,
        input  wr_tdata_i, wr_tvalid_i, ctrl_wstrb_msk_en_i, wr_tstrb_msk_i,
        output ctrl_rdone_o, rd_tdata_o, rd_tvalid_o, rd_tlast_o,
        output ctrl_wdone_o, wr_tready_o
    );
endinterface

// File: rtl/vcore_axim_mem_responder.sv
// Memory end of the vector core AXIM control/stream interface. Reads are streamed out of a
// word-addressed synchronous memory; write streams are absorbed into the same memory.
module vcore_axim_mem_responder #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH          = 1024
) (
    input logic                         clk,
    input logic                         reset,
    vcore_axim_mem_responder_if.slave   bus
);
    localparam int unsigned DW   = C_M_AXI_DATA_WIDTH;
    localparam int unsigned BL   = DW / 8;
    localparam int unsigned LSB  = $clog2(BL);
    localparam int unsigned IDXW = $clog2(MEM_DEPTH);
    localparam int unsigned CW   = C_XFER_SIZE_WIDTH + 1;

    typedef enum logic [1:0] {RIdle, RStream, RDone} rd_state_e;
    typedef enum logic [1:0] {WIdle, WAccept, WDone} wr_state_e;

    logic [DW-1:0] mem [MEM_DEPTH];
    logic [DW-1:0] mem_rdata_q;

    // Read channel state
    rd_state_e       rd_state_q, rd_state_d;
    logic [IDXW-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0]   rd_left_q, rd_left_d;   // memory reads still to issue
    logic            rd_pend_q, rd_pend_last_q;
    logic [DW-1:0]   rd_data_q, skid_data_q;
    logic            rd_valid_q, rd_last_q, skid_valid_q, skid_last_q;
    logic            rd_issue, rd_issue_last, rd_pop;
    logic [IDXW-1:0] rd_issue_idx;
    logic [CW-1:0]   rd_beats;
    logic [1:0]      rd_occ;

    // Write channel state
    wr_state_e       wr_state_q, wr_state_d;
    logic [IDXW-1:0] wr_idx_q, wr_idx_d;
    logic [CW-1:0]   wr_left_q, wr_left_d;
    logic            wr_we;
    logic [BL-1:0]   wr_be;
    logic [CW-1:0]   wr_beats;

    logic unused_offs;
    assign unused_offs = ^{bus.ctrl_raddr_offset_i, bus.ctrl_waddr_offset_i};

    // ceil(size / BL), one bit wider than the size so the rounding cannot overflow
    assign rd_beats = (CW'(bus.ctrl_rxfer_size_i) + CW'(BL - 1)) >> LSB;
    assign wr_beats = (CW'(bus.ctrl_wxfer_size_i) + CW'(BL - 1)) >> LSB;

    assign rd_pop = rd_valid_q & bus.rd_tready_i;
    // Beats held in output reg, skid reg and the memory read register, after this cycle's pop.
    // A new read is issued only if that total stays within the two output-side slots.
    assign rd_occ = 2'(rd_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(rd_pop);

    // Read FSM next state and memory read issue
    always_comb begin
        rd_state_d    = rd_state_q;
        rd_idx_d      = rd_idx_q;
        rd_left_d     = rd_left_q;
        rd_issue      = 1'b0;
        rd_issue_idx  = rd_idx_q;
        rd_issue_last = 1'b0;
        case (rd_state_q)
            RIdle: begin
                if (bus.ctrl_rstart_i) begin
                    if (rd_beats == '0) begin
                        rd_state_d = RDone;
                    end else begin
                        // First read goes out straight from the request so data lands 2 cycles on
                        rd_state_d    = RStream;
                        rd_issue      = 1'b1;
                        rd_issue_idx  = bus.ctrl_raddr_offset_i[LSB +: IDXW];
                        rd_issue_last = (rd_beats == CW'(1));
                        rd_idx_d      = bus.ctrl_raddr_offset_i[LSB +: IDXW] + IDXW'(1);
                        rd_left_d     = rd_beats - CW'(1);
                    end
                end
            end
            RStream: begin
                if (rd_left_q != '0 && rd_occ < 2'd2) begin
                    rd_issue      = 1'b1;
                    rd_issue_last = (rd_left_q == CW'(1));
                    rd_idx_d      = rd_idx_q + IDXW'(1);
                    rd_left_d     = rd_left_q - CW'(1);
                end
                if (rd_pop && rd_last_q) begin
                    rd_state_d = RDone;
                end
            end
            RDone:   rd_state_d = RIdle;
            default: rd_state_d = RIdle;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RIdle;
            rd_idx_q   <= '0;
            rd_left_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_left_q  <= rd_left_d;
        end
    end

    // Output and skid registers: the output holds while stalled, the skid catches the read in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
            skid_data_q    <= '0;
            skid_valid_q   <= 1'b0;
            skid_last_q    <= 1'b0;
        end else begin
            rd_pend_q      <= rd_issue;
            rd_pend_last_q <= rd_issue_last;
            if (!rd_valid_q || rd_pop) begin
                if (skid_valid_q) begin
                    rd_data_q    <= skid_data_q;
                    rd_last_q    <= skid_last_q;
                    rd_valid_q   <= 1'b1;
                    skid_valid_q <= rd_pend_q;
                    skid_data_q  <= mem_rdata_q;
                    skid_last_q  <= rd_pend_last_q;
                end else if (rd_pend_q) begin
                    rd_data_q  <= mem_rdata_q;
                    rd_last_q  <= rd_pend_last_q;
                    rd_valid_q <= 1'b1;
                end else begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_data_q  <= mem_rdata_q;
                skid_last_q  <= rd_pend_last_q;
                skid_valid_q <= 1'b1;
            end
        end
    end

    // Write FSM next state and memory write enables
    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_left_d  = wr_left_q;
        wr_we      = 1'b0;
        wr_be      = bus.ctrl_wstrb_msk_en_i ? bus.wr_tstrb_msk_i : '1;
        case (wr_state_q)
            WIdle: begin
                if (bus.ctrl_wstart_i) begin
                    wr_state_d = (wr_beats == '0) ? WDone : WAccept;
                    wr_idx_d   = bus.ctrl_waddr_offset_i[LSB +: IDXW];
                    wr_left_d  = wr_beats;
                end
            end
            WAccept: begin
                if (bus.wr_tvalid_i) begin
                    wr_we     = 1'b1;
                    wr_idx_d  = wr_idx_q + IDXW'(1);
                    wr_left_d = wr_left_q - CW'(1);
                    if (wr_left_q == CW'(1)) begin
                        wr_state_d = WDone;
                    end
                end
            end
            WDone:   wr_state_d = WIdle;
            default: wr_state_d = WIdle;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WIdle;
            wr_idx_q   <= '0;
            wr_left_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_left_q  <= wr_left_d;
        end
    end

    // Memory array: unreset so contents survive reset; read-first on same-word collisions
    always_ff @(posedge clk) begin
        if (rd_issue) begin
            mem_rdata_q <= mem[rd_issue_idx];
        end
        if (wr_we) begin
            for (int b = 0; b < BL; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx_q][b*8 +: 8] <= bus.wr_tdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign bus.rd_tdata_o   = rd_data_q;
    assign bus.rd_tvalid_o  = rd_valid_q;
    assign bus.rd_tlast_o   = rd_last_q;
    assign bus.ctrl_rdone_o = (rd_state_q == RDone);
    assign bus.wr_tready_o  = (wr_state_q == WAccept);
    assign bus.ctrl_wdone_o = (wr_state_q == WDone);
endmodule

// File: tb/tb_vcore_axim_mem_responder.sv
// Directed bench for vcore_axim_mem_responder: transfer table plus corner-case sequences.
module tb_vcore_axim_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vcore_axim_mem_responder_if bus ();

    vcore_axim_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit               is_wr;
        logic [31:0]      addr;
        logic [31:0]      size;
        int               n;
        bit               msk;
        logic [3:0]       strb;
        logic [3:0]       pat;     // rd_tready_i pattern, bit k used on cycle k mod 4
        logic [3:0][31:0] d;       // beat i in d[i]
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] s, int n, bit m,
                                logic [3:0] st, logic [3:0] p, logic [127:0] d);
        vec_t v;
        v.is_wr = w; v.addr = a; v.size = s; v.n = n; v.msk = m; v.strb = st; v.pat = p;
        v.d = d;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] size, input int n,
                            input bit msk, input logic [3:0] strb, input logic [3:0][31:0] d);
        int cyc;
        bus.ctrl_waddr_offset_i = addr;
        bus.ctrl_wxfer_size_i   = size;
        bus.ctrl_wstart_i       = 1'b1;
        bus.ctrl_wstrb_msk_en_i = msk;
        bus.wr_tstrb_msk_i      = strb;
        tick();
        bus.ctrl_wstart_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.wr_tvalid_i = 1'b1;
            bus.wr_tdata_i  = d[i];
            cyc = 0;
            while (!bus.wr_tready_o && cyc < 16) begin
                tick();
                cyc++;
            end
            chk("wr_ready", 32'(bus.wr_tready_o), 32'd1);
            chk("wdone_early", 32'(bus.ctrl_wdone_o), 32'd0);
            tick();
        end
        bus.wr_tvalid_i = 1'b0;
        chk("wdone_pulse", 32'(bus.ctrl_wdone_o), 32'd1);
        chk("wr_ready_drop", 32'(bus.wr_tready_o), 32'd0);
        tick();
        chk("wdone_end", 32'(bus.ctrl_wdone_o), 32'd0);
    endtask

    task automatic start_read(input logic [31:0] addr, input logic [31:0] size);
        bus.ctrl_raddr_offset_i = addr;
        bus.ctrl_rxfer_size_i   = size;
        bus.ctrl_rstart_i       = 1'b1;
        tick();
        bus.ctrl_rstart_i = 1'b0;
    endtask

    // Consume n beats under a ready pattern, checking order, tlast, stall stability and rdone
    task automatic collect_read(input logic [3:0][31:0] exp, input int n, input logic [3:0] pat,
                                input bit first_chk);
        int          got  = 0;
        int          cyc  = 0;
        bit          held = 1'b0;
        logic [31:0] hd   = '0;
        logic        hl   = 1'b0;
        while (got < n && cyc < 64) begin
            bus.rd_tready_i = pat[cyc % 4];
            if (first_chk && cyc == 0) chk("first_tvalid", 32'(bus.rd_tvalid_o), 32'd1);
            if (held) begin
                chk("stall_valid", 32'(bus.rd_tvalid_o), 32'd1);
                chk("stall_data", bus.rd_tdata_o, hd);
                chk("stall_last", 32'(bus.rd_tlast_o), 32'(hl));
            end
            held = 1'b0;
            if (bus.rd_tvalid_o && bus.rd_tready_i) begin
                chk("rd_data", bus.rd_tdata_o, exp[got]);
                chk("rd_last", 32'(bus.rd_tlast_o), 32'(got == n - 1));
                chk("rdone_early", 32'(bus.ctrl_rdone_o), 32'd0);
                got++;
            end else if (bus.rd_tvalid_o) begin
                held = 1'b1;
                hd   = bus.rd_tdata_o;
                hl   = bus.rd_tlast_o;
            end
            tick();
            cyc++;
        end
        bus.rd_tready_i = 1'b0;
        chk("rd_beats", 32'(got), 32'(n));
        chk("rdone_pulse", 32'(bus.ctrl_rdone_o), 32'd1);
        chk("tvalid_after", 32'(bus.rd_tvalid_o), 32'd0);
        tick();
        chk("rdone_end", 32'(bus.ctrl_rdone_o), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] size, input int n,
                           input logic [3:0] pat, input logic [3:0][31:0] d);
        start_read(addr, size);
        chk("tvalid_lat1", 32'(bus.rd_tvalid_o), 32'd0);
        tick();
        collect_read(d, n, pat, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ctrl_raddr_offset_i = '0; bus.ctrl_rxfer_size_i = '0; bus.ctrl_rstart_i = 1'b0;
        bus.rd_tready_i = 1'b0;
        bus.ctrl_waddr_offset_i = '0; bus.ctrl_wxfer_size_i = '0; bus.ctrl_wstart_i = 1'b0;
        bus.wr_tdata_i = '0; bus.wr_tvalid_i = 1'b0;
        bus.ctrl_wstrb_msk_en_i = 1'b0; bus.wr_tstrb_msk_i = '0;

        vecs[0] = mk(1, 32'h40, 16, 4, 0, 4'h0, 4'h0,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        vecs[1] = mk(0, 32'h40, 16, 4, 0, 4'h0, 4'b1111,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        vecs[2] = mk(0, 32'h40, 16, 4, 0, 4'h0, 4'b1001,
                     {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        vecs[3] = mk(1, 32'h40, 4, 1, 1, 4'b0101, 4'h0, {96'h0, 32'hAABBCCDD});
        vecs[4] = mk(0, 32'h40, 4, 1, 0, 4'h0, 4'b1111, {96'h0, 32'h11BB11DD});
        vecs[5] = mk(1, 32'hFFC, 8, 2, 0, 4'h0, 4'h0, {64'h0, 32'hCAFE0002, 32'hCAFE0001});
        vecs[6] = mk(0, 32'hFFC, 8, 2, 0, 4'h0, 4'b1111, {64'h0, 32'hCAFE0002, 32'hCAFE0001});
        vecs[7] = mk(1, 32'h103, 5, 2, 0, 4'h0, 4'h0, {64'h0, 32'h12345678, 32'h5555AAAA});
        vecs[8] = mk(0, 32'h100, 7, 2, 0, 4'h0, 4'b0110, {64'h0, 32'h12345678, 32'h5555AAAA});
        vecs[9] = mk(0, 32'h1040, 12, 3, 0, 4'h0, 4'b1111,
                     {32'h0, 32'h33333333, 32'h22222222, 32'h11BB11DD});

        // Reset state
        repeat (3) tick();
        chk("rst_tvalid", 32'(bus.rd_tvalid_o), 32'd0);
        chk("rst_tlast", 32'(bus.rd_tlast_o), 32'd0);
        chk("rst_tdata", bus.rd_tdata_o, 32'd0);
        chk("rst_rdone", 32'(bus.ctrl_rdone_o), 32'd0);
        chk("rst_wdone", 32'(bus.ctrl_wdone_o), 32'd0);
        chk("rst_wready", 32'(bus.wr_tready_o), 32'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].is_wr)
                do_write(vecs[v].addr, vecs[v].size, vecs[v].n, vecs[v].msk, vecs[v].strb,
                         vecs[v].d);
            else
                do_read(vecs[v].addr, vecs[v].size, vecs[v].n, vecs[v].pat, vecs[v].d);
            tick();
        end

        // Zero-size read: done pulse with no beat
        start_read(32'h40, 0);
        chk("z_rdone", 32'(bus.ctrl_rdone_o), 32'd1);
        chk("z_rvalid", 32'(bus.rd_tvalid_o), 32'd0);
        tick();
        chk("z_rdone_end", 32'(bus.ctrl_rdone_o), 32'd0);
        chk("z_rvalid_end", 32'(bus.rd_tvalid_o), 32'd0);

        // Zero-size write: done pulse, never ready
        bus.ctrl_waddr_offset_i = 32'h40; bus.ctrl_wxfer_size_i = 0; bus.ctrl_wstart_i = 1'b1;
        tick();
        bus.ctrl_wstart_i = 1'b0;
        chk("z_wdone", 32'(bus.ctrl_wdone_o), 32'd1);
        chk("z_wready", 32'(bus.wr_tready_o), 32'd0);
        tick();
        chk("z_wdone_end", 32'(bus.ctrl_wdone_o), 32'd0);
        tick();

        // Second rstart mid-stream is ignored
        start_read(32'h40, 16);
        tick();
        chk("ig_valid", 32'(bus.rd_tvalid_o), 32'd1);
        bus.ctrl_raddr_offset_i = 32'hFFC; bus.ctrl_rxfer_size_i = 8; bus.ctrl_rstart_i = 1'b1;
        tick();
        bus.ctrl_rstart_i = 1'b0;
        collect_read({32'h44444444, 32'h33333333, 32'h22222222, 32'h11BB11DD}, 4, 4'b1111,
                     1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("ig_no_restart", 32'(bus.rd_tvalid_o), 32'd0);
            chk("ig_no_rdone", 32'(bus.ctrl_rdone_o), 32'd0);
            tick();
        end

        // Reset mid-stream aborts without rdone; memory survives
        start_read(32'h40, 16);
        bus.rd_tready_i = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rd_tready_i = 1'b0;
        chk("rs_tvalid", 32'(bus.rd_tvalid_o), 32'd0);
        chk("rs_rdone", 32'(bus.ctrl_rdone_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rs_quiet_valid", 32'(bus.rd_tvalid_o), 32'd0);
            chk("rs_quiet_rdone", 32'(bus.ctrl_rdone_o), 32'd0);
        end
        do_read(32'h40, 16, 4, 4'b1111,
                {32'h44444444, 32'h33333333, 32'h22222222, 32'h11BB11DD});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
